// File: rtl/regfile_write_ctrl_if.sv
// Write-request channel from the datapath into the register-file write queue.
interface regfile_write_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write side: queues write requests and commits one per cycle
// as a registered one-hot enable, flagging reads that hit uncommitted writes.
module regfile_write_ctrl #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(NREGS),
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_write_ctrl_if.slave  wr,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [AW-1:0]        rd_addr,
  output logic                 hazard,
  output logic [NREGS-1:0]     reg_we,
  output logic [WIDTH-1:0]     reg_wdata,
  output logic [CW-1:0]        count
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NREGS-1:0] reg_we_q, reg_we_d;
  logic [WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  state_e           state_q, state_d;

  logic push, push_ok, pop;

  // wr_ready looks only at occupancy, never at a same-cycle pop
  assign wr.wr_ready = (count_q != CW'(DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;
  assign push_ok     = push && !flush;
  assign pop         = (count_q != '0) && !stall && !flush;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    reg_we_d    = '0;
    reg_wdata_d = reg_wdata_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop) begin
        rptr_d      = rptr_q + PW'(1);
        reg_wdata_d = data_q[rptr_q];
        // register 0 is hardwired and out-of-range addresses match no bit
        for (int unsigned i = 1; i < NREGS; i++) begin
          if (addr_q[rptr_q] == AW'(i)) reg_we_d[i] = 1'b1;
        end
      end
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push_ok) state_d = ACTIVE;
      ACTIVE:  if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      reg_we_q    <= '0;
      reg_wdata_q <= '0;
      state_q     <= IDLE;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      addr_q[wptr_q] <= wr.wr_addr;
      data_q[wptr_q] <= wr.wr_data;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off = PW'(i) - rptr_q;
      if (({1'b0, off} < count_q) && (addr_q[i] == rd_addr)) hazard = 1'b1;
    end
    // the in-flight enable covers the write landing at the next edge
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (reg_we_q[i] && (rd_addr == AW'(i))) hazard = 1'b1;
    end
    if (rd_addr == '0) hazard = 1'b0;
  end

  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_wdata_q;
  assign count     = count_q;

endmodule
